// File: rtl/mapper_noc_shell_pkg.sv
// Shared types and sizing helpers for the mapper NoC shell.
package mapper_noc_shell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_TEXT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Header flit: destination id in the top byte, record length in the bottom byte.
  localparam int HDR_ID_W  = 8;
  localparam int HDR_LEN_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mapper_noc_shell_sync_fifo_circ.sv
// Circular FIFO with an extra pointer MSB for full/empty; show-ahead read data, 1-cycle write-to-read.
// Caller must only push when not full (or when popping the same cycle); clr empties it synchronously.
module sync_fifo_circ #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/mapper_noc_shell.sv
// NoC shell for the mapper core: keyword/text intake with paced core feed, pair record assembly and TX.
// Text reaches the core >=2 cycles after acceptance; pairs leave 2 cycles after the last core word; TX stalls on fifo_in_ready.
module mapper_noc_shell
  import mapper_noc_shell_pkg::*;
#(
  parameter int         DW         = 32,
  parameter int         KEY_WORDS  = 4,
  parameter int         TEXT_DEPTH = 16,
  parameter int         PAIR_WORDS = 4,
  parameter int         PAIR_DEPTH = 8,
  parameter int         WR_GAP     = 6,
  parameter int         HDR_EN     = 0,
  parameter logic [7:0] DEST_ID    = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           data_in,
  input  logic                    data_in_ready,
  input  logic                    data_in_last,
  output logic                    in_ready,
  output logic [KEY_WORDS*DW-1:0] core_keyword,
  output logic                    core_key_en,
  output logic [DW-1:0]           core_text,
  output logic                    core_text_wr,
  input  logic                    core_busy,
  input  logic [DW-1:0]           core_pair,
  input  logic                    core_pair_valid,
  input  logic                    fifo_in_ready,
  output logic [DW-1:0]           data_out,
  output logic                    data_out_ready,
  output logic                    job_done,
  output logic                    pair_drop
);

  localparam int TAW     = $clog2(TEXT_DEPTH);
  localparam int PAW     = $clog2(PAIR_DEPTH);
  localparam int KIW     = idx_w(KEY_WORDS);
  localparam int AIW     = idx_w(PAIR_WORDS);
  localparam int PIW     = idx_w(PAIR_WORDS + 1);
  localparam int GW      = idx_w(WR_GAP);
  localparam int PW      = PAIR_WORDS * DW;
  localparam int TX_LAST = (HDR_EN != 0) ? PAIR_WORDS : PAIR_WORDS - 1;

  localparam logic [TAW:0]   TEXT_FULL = (TAW+1)'(TEXT_DEPTH);
  localparam logic [KIW-1:0] KEY_LAST  = KIW'(KEY_WORDS - 1);
  localparam logic [AIW-1:0] ASM_LAST  = AIW'(PAIR_WORDS - 1);
  localparam logic [PIW-1:0] TX_END    = PIW'(TX_LAST);
  localparam logic [PIW-1:0] HDR_SKIP  = PIW'((HDR_EN != 0) ? 1 : 0);

  state_t r_state, w_state_nxt;

  logic                    r_in_ready;
  logic                    r_key_en;
  logic [KEY_WORDS*DW-1:0] r_keyword;
  logic [KIW-1:0]          r_key_idx;
  logic [GW-1:0]           r_gap;
  logic [DW-1:0]           r_core_text;
  logic                    r_core_text_wr;
  logic                    r_job_done;
  logic                    r_pair_drop;
  logic [PW-1:0]           r_asm;
  logic [AIW-1:0]          r_asm_cnt;
  logic [PIW-1:0]          r_tx_idx;
  logic [DW-1:0]           r_data_out;
  logic                    r_data_out_ready;

  logic          w_new_job, w_accept, w_drain_done;
  logic          w_text_push, w_text_pop, w_text_full, w_text_empty;
  logic [DW-1:0] w_text_rdata;
  logic [TAW:0]  w_text_cnt, w_text_cnt_nxt;
  logic          w_asm_last, w_pair_push, w_pair_pop, w_pair_full, w_pair_empty, w_drop_evt;
  logic [PW-1:0] w_pair_rec, w_pair_rdata;
  logic [PAW:0]  w_pair_cnt;
  logic          w_tx_fire, w_tx_last;
  logic [PIW-1:0] w_word_idx;
  logic [DW-1:0] w_flit, w_hdr;

  assign w_accept       = data_in_ready && r_in_ready;
  assign w_text_push    = w_accept && (r_state == ST_TEXT) && !w_text_full;
  assign w_text_pop     = ((r_state == ST_TEXT) || (r_state == ST_DRAIN)) && (r_gap == '0) && !w_text_empty;
  assign w_text_cnt_nxt = w_text_cnt + (TAW+1)'(w_text_push) - (TAW+1)'(w_text_pop);
  assign w_drain_done   = w_text_empty && !core_busy && (r_asm_cnt == '0) && (w_pair_cnt == '0) && (r_tx_idx == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_new_job   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_in_ready) begin
          w_state_nxt = ST_KEY;
          w_new_job   = 1'b1;
        end
      end
      ST_KEY:   if (w_accept && (r_key_idx == KEY_LAST)) w_state_nxt = ST_TEXT;
      ST_TEXT:  if (w_accept && data_in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_keyword  <= '0;
      r_key_idx  <= '0;
      r_key_en   <= 1'b0;
      r_job_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // in_ready looks at the occupancy after this cycle's push/pop so it is exact next cycle.
      case (w_state_nxt)
        ST_KEY:  r_in_ready <= 1'b1;
        ST_TEXT: r_in_ready <= (w_text_cnt_nxt != TEXT_FULL);
        default: r_in_ready <= 1'b0;
      endcase
      if (w_new_job) begin
        r_key_idx <= '0;
      end else if (w_accept && (r_state == ST_KEY)) begin
        r_keyword[r_key_idx*DW +: DW] <= data_in;
        r_key_idx                     <= r_key_idx + KIW'(1);
      end
      r_key_en   <= w_accept && (r_state == ST_KEY) && (r_key_idx == KEY_LAST);
      r_job_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap          <= '0;
      r_core_text    <= '0;
      r_core_text_wr <= 1'b0;
    end else begin
      if (w_new_job)        r_gap <= '0;
      else if (w_text_pop)  r_gap <= GW'(WR_GAP - 1);
      else if (r_gap != '0) r_gap <= r_gap - GW'(1);
      if (w_text_pop) r_core_text <= w_text_rdata;
      r_core_text_wr <= w_text_pop;
    end
  end

  sync_fifo_circ #(.W(DW), .DEPTH(TEXT_DEPTH)) u_text_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_clr   (w_new_job),
    .i_push  (w_text_push),
    .i_wdata (data_in),
    .i_pop   (w_text_pop),
    .o_rdata (w_text_rdata),
    .o_full  (w_text_full),
    .o_empty (w_text_empty),
    .o_count (w_text_cnt)
  );

  always_comb begin
    w_pair_rec = r_asm;
    w_pair_rec[(PAIR_WORDS-1)*DW +: DW] = core_pair;
  end

  assign w_asm_last  = core_pair_valid && (r_asm_cnt == ASM_LAST);
  assign w_pair_push = w_asm_last && (!w_pair_full || w_pair_pop);
  assign w_drop_evt  = w_asm_last && !w_pair_push;

  // The pair path runs independently of the job FSM, so its FIFO is not cleared on a new job.
  sync_fifo_circ #(.W(PW), .DEPTH(PAIR_DEPTH)) u_pair_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_clr   (1'b0),
    .i_push  (w_pair_push),
    .i_wdata (w_pair_rec),
    .i_pop   (w_pair_pop),
    .o_rdata (w_pair_rdata),
    .o_full  (w_pair_full),
    .o_empty (w_pair_empty),
    .o_count (w_pair_cnt)
  );

  assign w_tx_fire  = !w_pair_empty && fifo_in_ready;
  assign w_tx_last  = w_tx_fire && (r_tx_idx == TX_END);
  assign w_pair_pop = w_tx_last;

  always_comb begin
    w_hdr = '0;
    w_hdr[DW-1 -: HDR_ID_W]  = DEST_ID;
    w_hdr[HDR_LEN_W-1:0]     = HDR_LEN_W'(PAIR_WORDS);
    w_word_idx = r_tx_idx - HDR_SKIP;
    w_flit     = '0;
    for (int i = 0; i < PAIR_WORDS; i++) begin
      if (w_word_idx == PIW'(i)) w_flit = w_pair_rdata[i*DW +: DW];
    end
    if ((HDR_EN != 0) && (r_tx_idx == '0)) w_flit = w_hdr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_asm            <= '0;
      r_asm_cnt        <= '0;
      r_pair_drop      <= 1'b0;
      r_tx_idx         <= '0;
      r_data_out       <= '0;
      r_data_out_ready <= 1'b0;
    end else begin
      if (core_pair_valid) begin
        r_asm[r_asm_cnt*DW +: DW] <= core_pair;
        r_asm_cnt                 <= w_asm_last ? '0 : r_asm_cnt + AIW'(1);
      end
      if (w_new_job)  r_pair_drop <= 1'b0;
      if (w_drop_evt) r_pair_drop <= 1'b1;
      if (w_tx_fire)  r_tx_idx <= w_tx_last ? '0 : r_tx_idx + PIW'(1);
      r_data_out_ready <= w_tx_fire;
      r_data_out       <= w_tx_fire ? w_flit : '0;
    end
  end

  assign in_ready       = r_in_ready;
  assign core_keyword   = r_keyword;
  assign core_key_en    = r_key_en;
  assign core_text      = r_core_text;
  assign core_text_wr   = r_core_text_wr;
  assign data_out       = r_data_out;
  assign data_out_ready = r_data_out_ready;
  assign job_done       = r_job_done;
  assign pair_drop      = r_pair_drop;

endmodule

// File: tb/tb_mapper_noc_shell.sv
// Directed bench: one headerless and one headered shell share all stimulus.
module tb_mapper_noc_shell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data_in;
  logic        data_in_ready, data_in_last, core_busy, core_pair_valid, fifo_in_ready;
  logic [31:0] core_pair;

  logic         a_in_ready, a_key_en, a_text_wr, a_dout_rdy, a_job_done, a_pair_drop;
  logic [127:0] a_keyword;
  logic [31:0]  a_text, a_dout;
  logic         h_in_ready, h_key_en, h_text_wr, h_dout_rdy, h_job_done, h_pair_drop;
  logic [127:0] h_keyword;
  logic [31:0]  h_text, h_dout;

  mapper_noc_shell u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_ready(data_in_ready),
    .data_in_last(data_in_last), .in_ready(a_in_ready), .core_keyword(a_keyword),
    .core_key_en(a_key_en), .core_text(a_text), .core_text_wr(a_text_wr),
    .core_busy(core_busy), .core_pair(core_pair), .core_pair_valid(core_pair_valid),
    .fifo_in_ready(fifo_in_ready), .data_out(a_dout), .data_out_ready(a_dout_rdy),
    .job_done(a_job_done), .pair_drop(a_pair_drop)
  );

  mapper_noc_shell #(.HDR_EN(1), .DEST_ID(8'h05)) u_dut_hdr (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_ready(data_in_ready),
    .data_in_last(data_in_last), .in_ready(h_in_ready), .core_keyword(h_keyword),
    .core_key_en(h_key_en), .core_text(h_text), .core_text_wr(h_text_wr),
    .core_busy(core_busy), .core_pair(core_pair), .core_pair_valid(core_pair_valid),
    .fifo_in_ready(fifo_in_ready), .data_out(h_dout), .data_out_ready(h_dout_rdy),
    .job_done(h_job_done), .pair_drop(h_pair_drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0, wr_cnt = 0, key_cnt = 0, jd_a = 0, jd_h = 0;
  int bad_flit = 0, bad_zero = 0, last_wr = -1, min_gap = 1000;
  logic [31:0] txt_q[$], qa[$], qh[$];

  always @(negedge clk) begin
    cyc++;
    if (a_text_wr) begin
      txt_q.push_back(a_text);
      if (last_wr >= 0 && (cyc - last_wr) < min_gap) min_gap = cyc - last_wr;
      last_wr = cyc;
      wr_cnt++;
    end
    if (a_key_en) key_cnt++;
    if (a_job_done) jd_a++;
    if (h_job_done) jd_h++;
    if (a_dout_rdy) begin
      qa.push_back(a_dout);
      if (!fifo_in_ready) bad_flit++;
    end
    if (h_dout_rdy) begin
      qh.push_back(h_dout);
      if (!fifo_in_ready) bad_flit++;
    end
    if (!a_dout_rdy && a_dout != 0) bad_zero++;
    if (!h_dout_rdy && h_dout != 0) bad_zero++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int n;
    n = 0;
    data_in = w; data_in_ready = 1'b1; data_in_last = last;
    while (!a_in_ready && n < 300) begin
      step();
      n++;
    end
    check_eq("send_ready", 128'(a_in_ready), 128'(1));
    step();
    data_in_ready = 1'b0; data_in_last = 1'b0;
  endtask

  task automatic send_keys(input logic [31:0] base);
    for (int k = 0; k < 4; k++) send(base + 32'(k), 1'b0);
  endtask

  task automatic wait_jobs(input int target);
    int n;
    n = 0;
    while ((jd_a < target || jd_h < target) && n < 800) begin
      step();
      n++;
    end
    check_eq("job_done_a", 128'(jd_a), 128'(target));
    check_eq("job_done_h", 128'(jd_h), 128'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, seen_full, bad, snap;
    logic [31:0] hexp [10];
    rst = 1'b0; data_in = '0; data_in_ready = 1'b0; data_in_last = 1'b0;
    core_busy = 1'b0; core_pair = '0; core_pair_valid = 1'b0; fifo_in_ready = 1'b1;
    repeat (3) step();
    check_eq("rst_in_ready", 128'(a_in_ready), 128'(0));
    check_eq("rst_keyword", a_keyword, 128'(0));
    check_eq("rst_text_wr", 128'(a_text_wr), 128'(0));
    check_eq("rst_dout_rdy", 128'(a_dout_rdy), 128'(0));
    check_eq("rst_pair_drop", 128'(a_pair_drop), 128'(0));
    check_eq("rst_job_done", 128'(a_job_done), 128'(0));
    rst = 1'b1;
    step();

    // Job A: basic keyword/text job plus two pairs under a 1/0 ready pattern.
    core_busy = 1'b1;
    send_keys(32'hA);
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b1);
    for (int i = 0; i < 40; i++) begin
      core_pair_valid = (i < 8);
      core_pair       = 32'(i + 1);
      fifo_in_ready   = (i % 2 == 0);
      step();
    end
    core_pair_valid = 1'b0; fifo_in_ready = 1'b1;
    check_eq("no_done_while_busy", 128'(jd_a), 128'(0));
    core_busy = 1'b0;
    wait_jobs(1);
    check_eq("key_en_count", 128'(key_cnt), 128'(1));
    check_eq("keyword", a_keyword, 128'h0000000D_0000000C_0000000B_0000000A);
    check_eq("text_count", 128'(txt_q.size()), 128'(3));
    check_eq("text0", 128'(txt_q[0]), 128'(32'h11));
    check_eq("text2", 128'(txt_q[2]), 128'(32'h33));
    check_eq("text_gap", 128'(min_gap), 128'(6));
    check_eq("pair_flits", 128'(qa.size()), 128'(8));
    for (int i = 0; i < 8; i++) check_eq("pair_seq", 128'(qa[i]), 128'(i + 1));
    hexp = '{32'h05000004, 1, 2, 3, 4, 32'h05000004, 5, 6, 7, 8};
    check_eq("hdr_flits", 128'(qh.size()), 128'(10));
    for (int i = 0; i < 10; i++) check_eq("hdr_seq", 128'(qh[i]), 128'(hexp[i]));

    // Job B: text overrun across pointer wrap, then pair FIFO overflow.
    txt_q.delete(); qa.delete(); qh.delete();
    core_busy = 1'b1; min_gap = 1000; last_wr = -1;
    send_keys(32'h1);
    base = wr_cnt; seen_full = 0;
    for (int i = 0; i < 24; i++) begin
      if (!a_in_ready && seen_full == 0) begin
        seen_full = 1;
        check_eq("occ_at_full", 128'(i - (wr_cnt - base)), 128'(16));
      end
      send(32'h1000 + 32'(i), i == 23);
    end
    check_eq("saw_full", 128'(seen_full), 128'(1));
    fifo_in_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i == 32) check_eq("no_drop_at_8", 128'(a_pair_drop), 128'(0));
      core_pair_valid = 1'b1;
      core_pair       = 32'h100 + 32'(i);
      step();
    end
    core_pair_valid = 1'b0;
    check_eq("drop_9th_a", 128'(a_pair_drop), 128'(1));
    check_eq("drop_9th_h", 128'(h_pair_drop), 128'(1));
    check_eq("no_flit_blocked", 128'(qa.size()), 128'(0));
    fifo_in_ready = 1'b1;
    core_busy = 1'b0;
    wait_jobs(2);
    check_eq("ovf_flits_a", 128'(qa.size()), 128'(32));
    for (int i = 0; i < 32; i++) check_eq("ovf_seq", 128'(qa[i]), 128'(32'h100 + 32'(i)));
    check_eq("ovf_flits_h", 128'(qh.size()), 128'(40));
    check_eq("ovf_hdr", 128'(qh[5]), 128'(32'h05000004));
    check_eq("burst_count", 128'(txt_q.size()), 128'(24));
    bad = 0;
    for (int i = 0; i < 24; i++) if (txt_q[i] !== 32'h1000 + 32'(i)) bad++;
    check_eq("burst_order", 128'(bad), 128'(0));
    check_eq("burst_gap", 128'(min_gap), 128'(6));
    check_eq("drop_sticky", 128'(a_pair_drop), 128'(1));

    // Job C: reset in the middle of TEXT with words buffered and a partial pair.
    core_busy = 1'b1;
    send(32'hC0, 1'b0);
    check_eq("drop_cleared", 128'(a_pair_drop), 128'(0));
    send(32'hC1, 1'b0); send(32'hC2, 1'b0); send(32'hC3, 1'b0);
    for (int i = 0; i < 6; i++) send(32'h500 + 32'(i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      core_pair_valid = 1'b1; core_pair = 32'h300 + 32'(i);
      step();
    end
    core_pair_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("mid_in_ready", 128'(a_in_ready), 128'(0));
    check_eq("mid_keyword", a_keyword, 128'(0));
    check_eq("mid_key_en", 128'(a_key_en), 128'(0));
    check_eq("mid_text", 128'(a_text), 128'(0));
    check_eq("mid_text_wr", 128'(a_text_wr), 128'(0));
    check_eq("mid_dout", 128'(a_dout), 128'(0));
    check_eq("mid_job_done", 128'(a_job_done), 128'(0));
    @(negedge clk);
    #1 rst = 1'b1;
    core_busy = 1'b0;
    base = wr_cnt; snap = jd_a;
    qa.delete();
    for (int i = 0; i < 4; i++) begin
      core_pair_valid = 1'b1; core_pair = 32'h200 + 32'(i);
      step();
    end
    core_pair_valid = 1'b0;
    repeat (20) step();
    check_eq("no_stale_text", 128'(wr_cnt - base), 128'(0));
    check_eq("no_done_on_rst", 128'(jd_a), 128'(snap));
    check_eq("post_rst_pairs", 128'(qa.size()), 128'(4));
    check_eq("post_rst_p0", 128'(qa[0]), 128'(32'h200));
    check_eq("post_rst_p3", 128'(qa[3]), 128'(32'h203));

    // Job D: fresh job after reset sees only its own text.
    txt_q.delete();
    send_keys(32'h20);
    send(32'h77, 1'b1);
    wait_jobs(3);
    check_eq("jobd_text_n", 128'(txt_q.size()), 128'(1));
    check_eq("jobd_text", 128'(txt_q[0]), 128'(32'h77));

    check_eq("flit_on_ready", 128'(bad_flit), 128'(0));
    check_eq("dout_zero_idle", 128'(bad_zero), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
